// File: rtl/fifo_packer.sv
// Packs RATIO narrow words into one wide word and writes it to a downstream FIFO.
// Optional macro PACKER_FLUSH_EN adds a flush input that emits a zero-padded partial word.
module fifo_packer #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned RATIO    = 2,
  parameter int unsigned CWIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         res_n,
  input  logic                         in_valid,
  input  logic [IN_WIDTH-1:0]          in_data,
  output logic                         in_ready,
  output logic                         fifo_shiftin,
  output logic [IN_WIDTH*RATIO-1:0]    fifo_data,
  input  logic                         fifo_full,
`ifdef PACKER_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [CWIDTH-1:0]            words_packed
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned ACC_WIDTH = OUT_WIDTH - IN_WIDTH;
  localparam int unsigned LCW       = $clog2(RATIO);

  logic [LCW-1:0]       lane_cnt_q, lane_cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] out_word_q, out_word_d;
  logic                 out_valid_q, out_valid_d;
  logic [CWIDTH-1:0]    cnt_q, cnt_d;

  logic last_lane;
  logic out_free;
  logic xfer;

  // Handshake: stall only when the final lane would need an occupied output register.
  assign last_lane    = (lane_cnt_q == LCW'(RATIO - 1));
  assign fifo_shiftin = out_valid_q && !fifo_full;
  assign out_free     = !out_valid_q || fifo_shiftin;
  assign in_ready     = !(last_lane && !out_free);
  assign xfer         = in_valid && in_ready;

  assign fifo_data    = out_word_q;
  assign words_packed = cnt_q;

  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    acc_d       = acc_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;

    if (fifo_shiftin) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CWIDTH'(1);
    end

    if (xfer) begin
      if (last_lane) begin
        out_word_d  = {in_data, acc_q};
        out_valid_d = 1'b1;
        lane_cnt_d  = '0;
      end else begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (LCW'(k) == lane_cnt_q) acc_d[k*IN_WIDTH +: IN_WIDTH] = in_data;
        end
        lane_cnt_d = lane_cnt_q + LCW'(1);
      end
    end

`ifdef PACKER_FLUSH_EN
    // Partial word (including any word accepted this cycle) leaves with unwritten lanes zeroed.
    if (flush && out_free && (lane_cnt_d != '0)) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        out_word_d[k*IN_WIDTH +: IN_WIDTH] =
          (LCW'(k) < lane_cnt_d) ? acc_d[k*IN_WIDTH +: IN_WIDTH] : IN_WIDTH'(0);
      end
      out_word_d[OUT_WIDTH-1 -: IN_WIDTH] = '0;
      out_valid_d = 1'b1;
      lane_cnt_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      lane_cnt_q  <= '0;
      acc_q       <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      acc_q       <= acc_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/fifo_packer.md
FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8: narrow input word width in bits (>=1).
REQ-002 Parameter RATIO, default 2: narrow words per wide word (>=2); OUT_WIDTH = IN_WIDTH*RATIO.
REQ-003 Parameter CWIDTH, default 16: width of the packed-word counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 res_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 in_valid  input  1  narrow word present on in_data.
REQ-007 in_data  input  IN_WIDTH  narrow word.
REQ-008 in_ready  output  1  block accepts in_data this cycle; transfer = in_valid && in_ready.
REQ-009 fifo_shiftin  output  1  write strobe to downstream FIFO shiftin.
REQ-010 fifo_data  output  OUT_WIDTH  packed word to downstream FIFO data_in.
REQ-011 fifo_full  input  1  downstream FIFO full flag (registered in FIFO).
REQ-012 words_packed  output  CWIDTH  count of wide words written to FIFO.
REQ-013 flush  input  1  present only with PACKER_FLUSH_EN; emit partial word.

Function
REQ-014 Accumulator holds up to RATIO-1 lanes plus lane counter lane_cnt (0..RATIO-1); first accepted narrow word lands in fifo_data[IN_WIDTH-1:0], lane k in bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
REQ-015 Output register (out_word, out_valid) holds one completed wide word; fifo_data SHALL equal out_word.
REQ-016 fifo_shiftin SHALL be combinational out_valid && !fifo_full; never asserted while fifo_full=1.
REQ-017 Output register is free at an edge when !out_valid or fifo_shiftin=1 in that cycle.
REQ-018 in_ready SHALL be 0 only when lane_cnt==RATIO-1 and output register not free; otherwise 1.
REQ-019 Transfer with lane_cnt<RATIO-1: write lane lane_cnt, lane_cnt+1.
REQ-020 Transfer with lane_cnt==RATIO-1: accumulator lanes plus in_data load out_word, out_valid=1 next cycle, lane_cnt=0; one-cycle latency from last narrow word to fifo_shiftin (if !fifo_full).
REQ-021 fifo_shiftin without a simultaneous load clears out_valid; simultaneous shift and load keeps out_valid=1 with new word (sustained one narrow word/cycle, one wide word per RATIO cycles).
REQ-022 State summary: EMPTY (lane_cnt=0,!out_valid), FILLING (lane_cnt>0), HOLD (out_valid); HOLD coexists with FILLING.
REQ-023 words_packed SHALL increment by 1 per fifo_shiftin and wrap modulo 2^CWIDTH.
REQ-024 in_data is ignored when in_valid=0; accumulator lanes not yet written hold don't-care, fifo_data only meaningful while out_valid=1.

Reset
REQ-025 res_n=0 at an edge: lane_cnt=0, out_valid=0, out_word=0, words_packed=0, accumulator=0; partial and held words discarded.
REQ-026 During reset cycles fifo_shiftin=0 (follows out_valid=0 after first reset edge); in_ready reflects reset state (1) from the first edge after reset.

Configuration
REQ-027 Macro PACKER_FLUSH_EN defined: flush port exists; flush=1 with lane_cnt>0 and output register free loads accumulator into out_word with unwritten lanes zero, lane_cnt=0, out_valid=1.
REQ-028 Flush with simultaneous in_valid transfer: in_data is included as lane lane_cnt before flush; if that completes RATIO lanes, behaviour equals REQ-020.
REQ-029 Flush with lane_cnt=0 and no transfer, or output register not free: no effect (flush is level, retried next cycle); in_ready unchanged by flush.
REQ-030 Macro PACKER_FLUSH_EN undefined: no flush port; partial words only leave via completion.

Verification (IN_WIDTH=8, RATIO=2, CWIDTH=16)
REQ-031 Inputs 0x11 then 0x22 on consecutive cycles, fifo_full=0 -> one fifo_shiftin pulse with fifo_data=0x2211 the cycle after 0x22, words_packed=1.
REQ-032 Continuous stream 0x01..0x08, fifo_full=0 -> in_ready stays 1, shiftin words 0x0201,0x0403,0x0605,0x0807, words_packed=4.
REQ-033 fifo_full=1 while 0xAA,0xBB,0xCC sent -> 0xBBAA held, in_ready=0 on 0xDD offer; release full -> 0xBBAA written, then 0xDDCC, no loss or duplication.
REQ-034 Send 0x55, assert res_n=0 one cycle, send 0x66,0x77 -> only 0x7766 written, words_packed=1.
REQ-035 PACKER_FLUSH_EN: send 0x33, flush=1 -> fifo_data=0x0033 written next cycle; flush with lane_cnt=0 -> no shiftin.
REQ-036 Counter wrap: preload via 65536 packed words -> words_packed returns to 0x0000.
